fetch_ctrl: RTL and testbench

Instruction-fetch controller that reads the core's program-counter register and drives the instruction-memory request. It fetches the word at the current PC, issues it to the execute stage, waits for execution to finish, then pulses the PC register's write enable so the next PC is latched. It sits between the PC register (whose enable it owns) and instruction memory, and it also detects halt, misalignment and memory-timeout conditions.

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch controller. Owns the PC register write enable,
//            drives the instruction-memory request and flags halt/errors.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_pc_en,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_inst_valid,
    input  logic                  i_exec_done,
    input  logic                  i_halt,
    output logic                  o_done,
    output logic [1:0]            o_err,
    output logic [CNT_WIDTH-1:0]  o_inst_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] c_TIMEOUT_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [1:0] c_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd2;

    logic [2:0]            r_state;
    logic                  r_settle;
    logic [TW-1:0]         r_tcnt;
    logic                  r_pc_en;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_done;
    logic [1:0]            r_err;
    logic [CNT_WIDTH-1:0]  r_inst_cnt;

    logic                  w_pc_aligned;
    logic                  w_req;

    assign w_pc_aligned = (i_pc[1:0] == 2'b00);

    // Request is combinational from state so that async reset drops it at once
    // and the address always tracks the live PC register output.
    assign w_req = (r_state == S_FETCH) && !r_settle && w_pc_aligned;

    assign o_imem_req   = w_req;
    assign o_imem_addr  = w_req ? i_pc : '0;
    assign o_inst_valid = (r_state == S_ISSUE);
    assign o_pc_en      = r_pc_en;
    assign o_inst       = r_inst;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_inst_cnt   = r_inst_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_settle   <= 1'b0;
            r_tcnt     <= '0;
            r_pc_en    <= 1'b0;
            r_inst     <= '0;
            r_done     <= 1'b0;
            r_err      <= 2'd0;
            r_inst_cnt <= '0;
        end else begin
            r_pc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_FETCH;
                        r_settle <= 1'b0;
                        r_tcnt   <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_settle) begin
                        // PC register latches during this cycle; present next.
                        r_settle <= 1'b0;
                        r_tcnt   <= '0;
                    end else if (!w_pc_aligned) begin
                        r_err   <= c_ERR_MISALIGN;
                        r_state <= S_HALT;
                    end else if (i_imem_valid) begin
                        r_inst  <= i_imem_data;
                        r_state <= S_ISSUE;
                    end else if (r_tcnt == c_TIMEOUT_LAST) begin
                        r_err   <= c_ERR_TIMEOUT;
                        r_state <= S_HALT;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (i_exec_done) begin
                        if (i_halt) begin
                            r_done  <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_pc_en    <= 1'b1;
                            r_inst_cnt <= r_inst_cnt + 1'b1;
                            r_settle   <= 1'b1;
                            r_tcnt     <= '0;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Bench for fetch_ctrl with PC register, memory and execute models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_pc;
    logic        o_pc_en;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_valid;
    logic [31:0] i_imem_data;
    logic [31:0] o_inst;
    logic        o_inst_valid;
    logic        i_exec_done;
    logic        i_halt;
    logic        o_done;
    logic [1:0]  o_err;
    logic [15:0] o_inst_cnt;

    fetch_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (16),
        .CNT_WIDTH  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_pc         (i_pc),
        .o_pc_en      (o_pc_en),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_valid (i_imem_valid),
        .i_imem_data  (i_imem_data),
        .o_inst       (o_inst),
        .o_inst_valid (o_inst_valid),
        .i_exec_done  (i_exec_done),
        .i_halt       (i_halt),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_inst_cnt   (o_inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        int          n_instr;
        int          mem_lat;
        int          exec_lat;
        int          exp_cnt;
        int          exp_done;
        int          exp_err;
        int          exp_pcen;
        int          exp_ivalid;
        int          exp_req;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] pc;
    bit          mem_en;
    bit          spur;
    int          mem_lat, exec_lat, n_instr;
    int          req_run, exec_wait, issue_idx;
    int          cyc, req_total, pcen_total, ivalid_total;
    logic [31:0] exp_q[$];
    vec_t        vecs[7];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of environment: sample DUT at negedge, update PC register,
    // score issued instructions, then drive memory/execute responses.
    task automatic tick();
        logic [31:0] exp_inst;
        @(negedge clk);
        cyc++;
        if (o_imem_req) begin
            req_total++;
            check("imem_addr", o_imem_addr, pc);
        end else begin
            check("imem_addr_idle", o_imem_addr, 0);
        end
        if (o_inst_valid) begin
            ivalid_total++;
            check("inst_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_inst = exp_q.pop_front();
                check("inst_data", o_inst, exp_inst);
            end
        end
        if (o_pc_en) begin
            pcen_total++;
            pc = pc + 32'd4;
        end

        i_exec_done = 1'b0;
        i_halt      = 1'b0;
        if (exec_wait > 0) begin
            exec_wait--;
            if (exec_wait == 0) begin
                i_exec_done = 1'b1;
                i_halt      = (issue_idx == n_instr);
            end
        end
        if (o_inst_valid) begin
            issue_idx++;
            exec_wait = exec_lat + 1;
        end
        if (spur && !i_exec_done) begin
            i_exec_done = 1'b1;
            i_halt      = 1'b1;
        end

        i_imem_valid = 1'b0;
        i_imem_data  = '0;
        if (o_imem_req && mem_en) begin
            if (req_run == mem_lat) begin
                i_imem_valid = 1'b1;
                i_imem_data  = mem_word(o_imem_addr);
                exp_q.push_back(mem_word(pc));
            end
            req_run++;
        end else begin
            req_run = 0;
        end
        if (spur && !o_imem_req) begin
            i_imem_valid = 1'b1;
            i_imem_data  = 32'hDEAD_BEEF;
        end
        i_pc = pc;
    endtask

    task automatic clear_env();
        exp_q.delete();
        req_run      = 0;
        exec_wait    = 0;
        issue_idx    = 0;
        req_total    = 0;
        pcen_total   = 0;
        ivalid_total = 0;
        i_imem_valid = 1'b0;
        i_imem_data  = '0;
        i_exec_done  = 1'b0;
        i_halt       = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_n   = 1'b0;
        i_start = 1'b0;
        spur    = 1'b0;
        mem_en  = 1'b1;
        pc      = pc0;
        i_pc    = pc0;
        clear_env();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_end();
        for (int k = 0; k < 3000; k++) begin
            if (o_done || o_err != 2'd0) break;
            tick();
        end
        check("run_terminates", (o_done || o_err != 2'd0), 1);
        repeat (4) tick();
    endtask

    task automatic final_check(input int cnt, input int done, input int err,
                               input int pcen, input int ivalid, input int req);
        check("inst_cnt", o_inst_cnt, cnt);
        check("done", o_done, done);
        check("err", o_err, err);
        check("pc_en_pulses", pcen_total, pcen);
        check("inst_valid_pulses", ivalid_total, ivalid);
        check("req_cycles", req_total, req);
        check("scoreboard_empty", exp_q.size(), 0);
        check("req_low_at_end", o_imem_req, 0);
    endtask

    initial begin
        int r_cyc, e_cyc;
        cyc = 0;
        //               pc          n  mem exe cnt dn er pce ivl req
        vecs[0] = '{32'h0000_0000, 3,  1, 0,  2, 1, 0,  2,  3,  6};
        vecs[1] = '{32'h0000_0100, 2,  5, 2,  1, 1, 0,  1,  2, 12};
        vecs[2] = '{32'h0000_0040, 4,  2, 0,  3, 1, 0,  3,  4, 12};
        vecs[3] = '{32'h0000_0006, 1,  1, 0,  0, 0, 1,  0,  0,  0};
        vecs[4] = '{32'h0000_0001, 2,  1, 0,  0, 0, 1,  0,  0,  0};
        vecs[5] = '{32'h0000_0000, 1, 15, 0,  0, 1, 0,  0,  1, 16};
        vecs[6] = '{32'h0000_0000, 1, 16, 0,  0, 0, 2,  0,  0, 16};

        do_reset(32'h0);
        #1;
        check("rst_req", o_imem_req, 0);
        check("rst_addr", o_imem_addr, 0);
        check("rst_pc_en", o_pc_en, 0);
        check("rst_inst", o_inst, 0);
        check("rst_inst_valid", o_inst_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_cnt", o_inst_cnt, 0);

        foreach (vecs[i]) begin
            do_reset(vecs[i].start_pc);
            mem_lat  = vecs[i].mem_lat;
            exec_lat = vecs[i].exec_lat;
            n_instr  = vecs[i].n_instr;
            i_start  = 1'b1;
            tick();
            i_start  = 1'b0;
            wait_end();
            final_check(vecs[i].exp_cnt, vecs[i].exp_done, vecs[i].exp_err,
                        vecs[i].exp_pcen, vecs[i].exp_ivalid, vecs[i].exp_req);
        end

        // Timeout latency and insensitivity of the halted state.
        do_reset(32'h0000_0020);
        mem_en  = 1'b0;
        n_instr = 1;
        r_cyc   = -1;
        e_cyc   = -1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_imem_req && r_cyc < 0) r_cyc = cyc;
            if (o_err != 2'd0) begin
                e_cyc = cyc;
                break;
            end
            tick();
        end
        check("timeout_latency", e_cyc - r_cyc, 16);
        check("timeout_err", o_err, 2);
        check("timeout_req_low", o_imem_req, 0);
        spur    = 1'b1;
        i_start = 1'b1;
        repeat (10) tick();
        i_start = 1'b0;
        spur    = 1'b0;
        check("halt_err_sticky", o_err, 2);
        check("halt_no_done", o_done, 0);
        check("halt_no_issue", ivalid_total, 0);
        check("halt_no_pc_en", pcen_total, 0);
        check("halt_req_cycles", req_total, 16);

        // Spurious valid/exec_done/start everywhere outside their states.
        do_reset(32'h0000_0000);
        spur = 1'b1;
        repeat (8) tick();
        check("idle_no_req", req_total, 0);
        check("idle_no_issue", ivalid_total, 0);
        check("idle_no_pc_en", pcen_total, 0);
        check("idle_cnt", o_inst_cnt, 0);
        check("idle_done", o_done, 0);
        check("idle_err", o_err, 0);
        clear_env();
        mem_lat  = 1;
        exec_lat = 0;
        n_instr  = 3;
        i_start  = 1'b1;
        wait_end();
        final_check(2, 1, 0, 2, 3, 6);
        repeat (8) tick();
        check("halt_cnt_hold", o_inst_cnt, 2);
        check("halt_issue_hold", ivalid_total, 3);
        check("halt_done_hold", o_done, 1);
        i_start = 1'b0;
        spur    = 1'b0;

        // Asynchronous reset while a request is outstanding.
        do_reset(32'h0000_0000);
        mem_lat  = 5;
        exec_lat = 0;
        n_instr  = 3;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (o_inst_cnt == 16'd1 && o_imem_req && req_run == 2) break;
            tick();
        end
        check("midfetch_reached", (o_inst_cnt == 16'd1 && o_imem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", o_imem_req, 0);
        check("arst_addr", o_imem_addr, 0);
        check("arst_pc_en", o_pc_en, 0);
        check("arst_inst", o_inst, 0);
        check("arst_inst_valid", o_inst_valid, 0);
        check("arst_done", o_done, 0);
        check("arst_err", o_err, 0);
        check("arst_cnt", o_inst_cnt, 0);
        @(negedge clk);
        clear_env();
        rst_n   = 1'b1;
        n_instr = 2;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_end();
        final_check(1, 1, 0, 1, 2, 12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
